// File: rtl/ticket_entry.sv
// Ticket entry front-end: synchronizes and debounces the player controls and issues
// single-cycle strobes to the checker. Optional TICKET_LOG_EN adds a shift-register ticket log.
module ticket_entry #(
    parameter int unsigned NUM_DIGITS      = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn_ok,
    input  logic       btn_clear,
    output logic [3:0] num,
    output logic       insere,
    output logic       fim,
    output logic       fim_jogo,
    output logic       erro,
    output logic [2:0] digit_cnt,
    output logic       busy
`ifdef TICKET_LOG_EN
    ,
    output logic [4*NUM_DIGITS-1:0] ticket
`endif
);

    typedef enum logic [2:0] {StIdle, StIssue, StGap, StClose, StDone} state_e;

    // Index 0 is the ok button, index 1 the clear button.
    logic [1:0] btn_raw, btn_s1, btn_s2, deb_q, press_q;
    logic [7:0] db_cnt_q [2];
    logic [3:0] sw_s1, sw_s2;

    assign btn_raw = {btn_clear, btn_ok};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1      <= '0;
            btn_s2      <= '0;
            deb_q       <= '0;
            press_q     <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            sw_s1       <= '0;
            sw_s2       <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= 1'b0;
                if (btn_s2[i] != deb_q[i]) begin
                    if (db_cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                        deb_q[i]    <= btn_s2[i];
                        db_cnt_q[i] <= '0;
                        press_q[i]  <= btn_s2[i];
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    state_e     state_q, state_d;
    logic [3:0] num_q, num_d, sw_cap_q, sw_cap_d;
    logic [2:0] cnt_q, cnt_d;
    logic       insere_q, insere_d, fim_q, fim_d, fim_jogo_q, fim_jogo_d, erro_q, erro_d;
`ifdef TICKET_LOG_EN
    logic [4*NUM_DIGITS-1:0] ticket_q, ticket_d;
    logic [4*NUM_DIGITS+3:0] ticket_shift;
    assign ticket_shift = {ticket_q, sw_cap_q};
`endif

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        sw_cap_d   = sw_cap_q;
        cnt_d      = cnt_q;
        insere_d   = 1'b0;
        fim_d      = 1'b0;
        fim_jogo_d = 1'b0;
        erro_d     = 1'b0;
`ifdef TICKET_LOG_EN
        ticket_d   = ticket_q;
`endif
        // Clear overrides everything, including a concurrent ok press or a pending close.
        if (press_q[1]) begin
            state_d    = StIdle;
            fim_jogo_d = 1'b1;
            cnt_d      = '0;
            num_d      = '0;
`ifdef TICKET_LOG_EN
            ticket_d   = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (press_q[0]) begin
                        sw_cap_d = sw_s2;
                        state_d  = StIssue;
                    end
                end
                StIssue: begin
                    if (sw_cap_q <= 4'd9) begin
                        num_d    = sw_cap_q;
                        insere_d = 1'b1;
                        cnt_d    = cnt_q + 3'd1;
`ifdef TICKET_LOG_EN
                        ticket_d = ticket_shift[4*NUM_DIGITS-1:0];
`endif
                        state_d  = (cnt_d == 3'(NUM_DIGITS)) ? StGap : StIdle;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                StGap:   state_d = StClose;
                StClose: begin
                    fim_d   = 1'b1;
                    state_d = StDone;
                end
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            num_q      <= '0;
            sw_cap_q   <= '0;
            cnt_q      <= '0;
            insere_q   <= 1'b0;
            fim_q      <= 1'b0;
            fim_jogo_q <= 1'b0;
            erro_q     <= 1'b0;
`ifdef TICKET_LOG_EN
            ticket_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            sw_cap_q   <= sw_cap_d;
            cnt_q      <= cnt_d;
            insere_q   <= insere_d;
            fim_q      <= fim_d;
            fim_jogo_q <= fim_jogo_d;
            erro_q     <= erro_d;
`ifdef TICKET_LOG_EN
            ticket_q   <= ticket_d;
`endif
        end
    end

    assign num       = num_q;
    assign insere    = insere_q;
    assign fim       = fim_q;
    assign fim_jogo  = fim_jogo_q;
    assign erro      = erro_q;
    assign digit_cnt = cnt_q;
    assign busy      = (cnt_q != 3'd0) && (state_q != StDone);
`ifdef TICKET_LOG_EN
    assign ticket    = ticket_q;
`endif

endmodule
